// File: rtl/drac_icache_pkg.sv
// Shared types for the icache line-fill path: request/response layouts, beat counts, fill FSM states.
package drac_icache_pkg;

  localparam int ICACHE_LINE_BEATS = 4;
  localparam int IFILL_PADDR_W     = 26;
  localparam int IFILL_DATA_W      = 128;
  localparam int IFILL_REQ_W       = IFILL_PADDR_W + 3;
  localparam int IFILL_RESP_W      = IFILL_DATA_W + 4;

  typedef struct packed {
    logic                     valid;
    logic [1:0]               way;
    logic [IFILL_PADDR_W-1:0] paddr;
  } ifill_req_t;

  typedef struct packed {
    logic                    valid;
    logic                    ack;
    logic [IFILL_DATA_W-1:0] data;
    logic [1:0]              beat;
  } ifill_resp_t;

  typedef enum logic [1:0] {
    IFILL_IDLE,
    IFILL_ISSUE,
    IFILL_DRAIN
  } ifill_state_e;

  // Wide enough to hold BEATS itself, so "all beats done" is a plain compare.
  typedef logic [2:0] beat_cnt_t;

  function automatic logic [IFILL_PADDR_W+5:0] beat_addr(input logic [IFILL_PADDR_W-1:0] paddr,
                                                          input logic [1:0]               beat);
    return {paddr, beat, 4'b0000};
  endfunction

endpackage

// File: rtl/icache_ifill_responder.sv
// Memory-side icache line filler: one 64 B line in flight, fetched as 4 x 128-bit beats.
// Latency: first mem request 1 cycle after accept, each beat 1 cycle after mem rsp; mem ready stalls issue, rsp never stalled.
module icache_ifill_responder
  import drac_icache_pkg::*;
#(
  parameter int PADDR_W    = IFILL_PADDR_W,
  parameter int MEM_ADDR_W = PADDR_W + 6,
  parameter int BEATS      = ICACHE_LINE_BEATS,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PADDR_W+2:0]      ifill_req_i,
  output logic [IFILL_RESP_W-1:0] ifill_resp_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [MEM_ADDR_W-1:0]   mem_req_addr_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [IFILL_DATA_W-1:0] mem_rsp_data_i,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam beat_cnt_t LINE_CNT  = beat_cnt_t'(BEATS);
  localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);
  localparam beat_cnt_t OUTST_CNT = beat_cnt_t'(MAX_OUTST);

  ifill_req_t   req;
  ifill_state_e state_q, state_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  beat_cnt_t    issue_cnt_q, issue_cnt_d;
  beat_cnt_t    rcv_cnt_q, rcv_cnt_d;
  beat_cnt_t    outstanding;
  ifill_resp_t  resp_q, resp_d;
  logic         overrun_q;
  logic         line_active;
  logic         rsp_take;
  logic         unused_way;

  assign req         = ifill_req_i;
  // The icache tracks its own victim way, so the way field is deliberately dropped.
  assign unused_way  = ^req.way;
  assign line_active = (state_q != IFILL_IDLE);
  assign outstanding = issue_cnt_q - rcv_cnt_q;
  // Responses outside a live line (e.g. leftovers after reset) are discarded.
  assign rsp_take    = mem_rsp_valid_i && line_active && (rcv_cnt_q != LINE_CNT);

  always_comb begin
    state_d         = state_q;
    paddr_d         = paddr_q;
    issue_cnt_d     = issue_cnt_q;
    rcv_cnt_d       = rcv_cnt_q;
    mem_req_valid_o = 1'b0;

    if (rsp_take) begin
      rcv_cnt_d = rcv_cnt_q + 3'd1;
    end

    case (state_q)
      IFILL_IDLE: begin
        if (req.valid) begin
          paddr_d     = req.paddr;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          state_d     = IFILL_ISSUE;
        end
      end
      IFILL_ISSUE: begin
        mem_req_valid_o = (outstanding < OUTST_CNT);
        if (mem_req_valid_o && mem_req_ready_i) begin
          issue_cnt_d = issue_cnt_q + 3'd1;
          if (issue_cnt_d == LINE_CNT) begin
            state_d = IFILL_DRAIN;
          end
        end
      end
      IFILL_DRAIN: begin
        // rcv_cnt hits LINE_CNT in the cycle the last beat is on ifill_resp_o; leave after it.
        if (rcv_cnt_q == LINE_CNT) begin
          state_d = IFILL_IDLE;
        end
      end
      default: state_d = IFILL_IDLE;
    endcase
  end

  always_comb begin
    resp_d = '0;
    if (rsp_take) begin
      resp_d.valid = 1'b1;
      resp_d.ack   = (rcv_cnt_q == LAST_BEAT);
      resp_d.data  = mem_rsp_data_i;
      resp_d.beat  = rcv_cnt_q[1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IFILL_IDLE;
      paddr_q     <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      resp_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      resp_q      <= resp_d;
      overrun_q   <= overrun_q | (req.valid & line_active);
    end
  end

  assign mem_req_addr_o = MEM_ADDR_W'(beat_addr(paddr_q, issue_cnt_q[1:0]));
  assign ifill_resp_o   = resp_q;
  assign busy_o         = line_active;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_icache_ifill_responder.sv
// Bench for icache_ifill_responder: cycle table for a basic fill, then randomized memory timing
// checked against a line-level scoreboard (expected beats derived from the requested paddr).
module tb_icache_ifill_responder;

  localparam int          TB_OUTST = 2;
  localparam int          NV       = 10;
  localparam logic [25:0] TBL_P    = 26'h0ABCDE;
  localparam logic [31:0] TBL_BASE = 32'h02AF3780;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [28:0]  ifill_req_i;
  logic [131:0] ifill_resp_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [127:0] mem_rsp_data_i;
  logic         busy_o;
  logic         overrun_o;

  always #5 clk_i = ~clk_i;

  icache_ifill_responder #(.MAX_OUTST(TB_OUTST)) u_dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ifill_req_i     (ifill_req_i),
    .ifill_resp_o    (ifill_resp_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  typedef struct {
    logic         req;
    logic         rdy;
    logic         rsp;
    logic [127:0] rdat;
    logic         busy;
    logic         mvld;
    logic [31:0]  maddr;
    logic         rvld;
    logic         rack;
    logic [1:0]   rbeat;
    logic [127:0] rdata;
  } vec_t;

  typedef struct {
    logic [25:0] paddr;
    logic [1:0]  beat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NV];

  exp_t  exp_q[$];
  pend_t pend_q[$];
  bit    mem_auto = 1'b0;
  bit    sb_en    = 1'b0;
  int    ready_pct = 100, lat_min = 2, lat_max = 2, hold_low = 0;
  int    cyc = 0, last_due = 0;
  int    issued = 0, rcvd = 0, max_out = 0, stall_cnt = 0, unexp_cnt = 0;
  bit    prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mdata(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0123_4567};
  endfunction

  function automatic logic [127:0] dpat(input int k);
    return {4{32'hC0DE_0000 | 32'(k)}};
  endfunction

  function automatic vec_t mk(input logic req, input logic rdy, input logic rsp, input int rk,
                              input logic busy, input logic mvld, input int ak,
                              input logic rvld, input logic rack, input int bk);
    vec_t v;
    v.req   = req;   v.rdy  = rdy;  v.rsp   = rsp;  v.rdat = dpat(rk);
    v.busy  = busy;  v.mvld = mvld; v.maddr = TBL_BASE + 32'(ak * 16);
    v.rvld  = rvld;  v.rack = rack; v.rbeat = 2'(bk); v.rdata = dpat(bk);
    return v;
  endfunction

  // Memory model: in-order responses after a random latency, random or forced-low ready.
  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
      #2;
      if (mem_auto) begin
        if (hold_low > 0) begin
          mem_req_ready_i = 1'b0;
          hold_low--;
        end else begin
          mem_req_ready_i = (int'($urandom_range(99, 0)) < ready_pct);
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = mdata(pend_q[0].addr);
          void'(pend_q.pop_front());
        end else begin
          mem_rsp_valid_i = 1'b0;
          mem_rsp_data_i  = {4{$urandom}};
        end
      end
      @(negedge clk_i);
      if (mem_auto && mem_req_valid_o && mem_req_ready_i) begin
        pend_t p;
        p.addr = mem_req_addr_o;
        p.due  = cyc + int'($urandom_range(lat_max, lat_min));
        if (p.due <= last_due) p.due = last_due + 1;
        last_due = p.due;
        pend_q.push_back(p);
      end
    end
  end

  // Scoreboard / protocol monitor.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete();
        issued     = 0;
        rcvd       = 0;
        prev_stall = 1'b0;
      end else if (sb_en) begin
        if (ifill_resp_o[131]) begin
          rcvd++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            unexp_cnt++;
            $display("FAIL unexpected_beat: got resp %0h, expected no beat", ifill_resp_o);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("beat", 192'(ifill_resp_o),
                192'({1'b1, e.beat == 2'd3, mdata({e.paddr, e.beat, 4'b0000}), e.beat}));
          end
        end
        if (prev_stall) begin
          chk("bp_hold", 192'({mem_req_valid_o, mem_req_addr_o}), 192'({1'b1, prev_addr}));
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
          chk("outst_limit", 192'(issued - rcvd < TB_OUTST), 192'(1));
          issued++;
          if (issued - rcvd > max_out) max_out = issued - rcvd;
        end
        prev_stall = mem_req_valid_o && !mem_req_ready_i;
        prev_addr  = mem_req_addr_o;
        if (prev_stall) stall_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_req(input logic [25:0] p, input bit expect_accept);
    ifill_req_i = {1'b1, 2'($urandom), p};
    if (expect_accept) begin
      for (int k = 0; k < 4; k++) begin
        exp_t e;
        e.paddr = p;
        e.beat  = 2'(k);
        exp_q.push_back(e);
      end
    end
    tick();
    ifill_req_i = '0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, busy=%0b pending_beats=%0d, expected idle", name, busy_o, exp_q.size());
    end
    tick();
  endtask

  task automatic send_line(input logic [25:0] p);
    pulse_req(p, 1'b1);
    wait_idle(400, "line_done");
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT event, expected it within budget", name);
  endtask

  initial begin
    int n, hs, ub;
    logic [166:0] act_v, exp_v;

    ifill_req_i     = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    rst_i           = 1'b1;

    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[2] = mk(0, 1, 0, 0, 1, 1, 1, 0, 0, 0);
    vecs[3] = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    vecs[4] = mk(0, 1, 1, 1, 1, 1, 2, 1, 0, 0);
    vecs[5] = mk(0, 1, 0, 0, 1, 1, 3, 1, 0, 1);
    vecs[6] = mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    vecs[7] = mk(0, 1, 1, 3, 1, 0, 0, 1, 0, 2);
    vecs[8] = mk(0, 0, 0, 0, 1, 0, 0, 1, 1, 3);
    vecs[9] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_outputs",
        192'({ifill_resp_o, mem_req_valid_o, mem_req_addr_o, busy_o, overrun_o}), 192'(0));
    tick();
    rst_i = 1'b0;

    // Cycle-exact basic fill: ready always high, each response 2 cycles after its request.
    for (int i = 0; i < NV; i++) begin
      ifill_req_i     = vecs[i].req ? {1'b1, 2'b01, TBL_P} : 29'h0;
      mem_req_ready_i = vecs[i].rdy;
      mem_rsp_valid_i = vecs[i].rsp;
      mem_rsp_data_i  = vecs[i].rdat;
      @(negedge clk_i);
      act_v = {busy_o, mem_req_valid_o, mem_req_valid_o ? mem_req_addr_o : 32'h0,
               ifill_resp_o[131], ifill_resp_o[131] ? ifill_resp_o[130:0] : 131'h0, overrun_o};
      exp_v = {vecs[i].busy, vecs[i].mvld, vecs[i].mvld ? vecs[i].maddr : 32'h0,
               vecs[i].rvld, vecs[i].rvld ? {vecs[i].rack, vecs[i].rdata, vecs[i].rbeat} : 131'h0,
               1'b0};
      chk($sformatf("vec%0d", i), 192'(act_v), 192'(exp_v));
      tick();
    end

    ifill_req_i = '0;
    mem_auto    = 1'b1;
    sb_en       = 1'b1;

    // Basic fill through the memory model.
    ready_pct = 100; lat_min = 2; lat_max = 2;
    send_line(TBL_P);

    // Backpressure: ready low for the first 5 ISSUE cycles.
    stall_cnt = 0;
    hold_low  = 6;
    send_line(26'h2345AB);
    chk("bp_stall_cycles", 192'(stall_cnt), 192'(5));

    // Long memory latency: outstanding must saturate at the limit, never beyond.
    lat_min = 6; lat_max = 9; max_out = 0;
    send_line(26'h3F0F0F);
    chk("outst_peak", 192'(max_out), 192'(TB_OUTST));

    // Overrun: extra request while the line drains.
    lat_min = 3; lat_max = 5;
    chk("overrun_pre", 192'(overrun_o), 192'(0));
    pulse_req(26'h155555, 1'b1);
    n = 0; hs = 0;
    while (hs < 4 && n < 200) begin
      @(negedge clk_i);
      if (mem_req_valid_o && mem_req_ready_i) hs++;
      n++;
    end
    if (hs < 4) timeout_fail("overrun_issue");
    tick();
    chk("overrun_busy", 192'(busy_o), 192'(1));
    pulse_req(26'h2AAAAA, 1'b0);
    wait_idle(400, "overrun_line");
    chk("overrun_set", 192'(overrun_o), 192'(1));
    send_line(26'h0F0F0F);
    chk("overrun_sticky", 192'(overrun_o), 192'(1));

    // Reset in the middle of a line, after beat 1 is out.
    lat_min = 2; lat_max = 4;
    pulse_req(26'h3C3C3C, 1'b1);
    n = 0;
    while (!(ifill_resp_o[131] && ifill_resp_o[1:0] == 2'd1) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) timeout_fail("midline_beat1");
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("reset_midline",
        192'({ifill_resp_o, mem_req_valid_o, mem_req_addr_o, busy_o, overrun_o}), 192'(0));
    tick();
    rst_i = 1'b0;
    ub = unexp_cnt;
    n = 0;
    while (pend_q.size() != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    chk("stray_beats", 192'(unexp_cnt - ub), 192'(0));
    chk("stray_idle", 192'(busy_o), 192'(0));
    tick();
    send_line(26'h0C0FFE);

    // Back-to-back: new request on the first IDLE cycle after the ack beat.
    lat_min = 1; lat_max = 3;
    pulse_req(26'h111111, 1'b1);
    n = 0;
    while (!(ifill_resp_o[131] && ifill_resp_o[130]) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) timeout_fail("b2b_ack");
    tick();
    pulse_req(26'h222222, 1'b1);
    @(negedge clk_i);
    chk("b2b_accept", 192'({busy_o, overrun_o}), 192'(2'b10));
    wait_idle(400, "b2b_line");

    // Randomized memory timing.
    for (int l = 0; l < 25; l++) begin
      ready_pct = int'($urandom_range(100, 30));
      lat_min   = 1;
      lat_max   = int'($urandom_range(8, 1));
      if ($urandom_range(3, 0) == 0) hold_low = int'($urandom_range(6, 1));
      send_line(26'($urandom));
    end
    chk("final_state", 192'({busy_o, overrun_o, exp_q.size() == 0}), 192'(3'b001));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
